// File: rtl/seg_disp_pkg.sv
// Shared constants, state type and digit-select decode for the 3-digit
// 7-segment display slice.
package seg_disp_pkg;

    localparam int unsigned N_DIG = 3;

    // Active-low digit selects
    localparam logic [2:0] DIG0_SEL = 3'b110;
    localparam logic [2:0] DIG1_SEL = 3'b101;
    localparam logic [2:0] DIG2_SEL = 3'b011;
    localparam logic [2:0] DIG_OFF  = 3'b111;

    localparam logic [7:0] SEG_OFF  = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scanState_t;

    // Digit index to active-low select; the unused index 3 maps to all-off
    function automatic logic [2:0] digitSel(input logic [1:0] dig);
        case (dig)
            2'd0:    return DIG0_SEL;
            2'd1:    return DIG1_SEL;
            2'd2:    return DIG2_SEL;
            default: return DIG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_div.sv
// Free-running divider: counts 0..DIV-1 while enabled and emits a one-cycle
// tick on the last count. Synchronous clear holds the count at zero.
module tick_div #(
    parameter int unsigned DIV = 12000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iCLR,
    input  logic iEN,
    output logic oTICK
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign oTICK = iEN && (cnt == LAST);

    // Count register: wraps to zero on the tick, cleared by reset or iCLR
    always_ff @(posedge iCLK) begin
        if (!iRST_N || iCLR) begin
            cnt <= '0;
        end else if (iEN) begin
            cnt <= oTICK ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 3-digit 7-segment display. Frames arrive through a
// valid/ready handshake into a shadow buffer and are promoted to the active
// buffer only at a frame boundary, so a frame is never torn across digits.
// Optional macro SEG_BLANK_EN inserts BLANK_CYC all-off cycles after every
// digit slot to suppress ghosting.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 12000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] iFRAME,
    input  logic        iFRAME_VLD,
    output logic        oFRAME_RDY,
    output logic [7:0]  seg,
    output logic [2:0]  baza,
    output logic        oFRAME_DONE
);

    if (TICK_DIV < 2 || TICK_DIV > (1 << 20) || BLANK_CYC < 1 || BLANK_CYC > 255) begin : gBadParam
        $error("seg_scan_ctrl: TICK_DIV or BLANK_CYC out of range");
    end

    localparam logic [1:0] LAST_DIG = 2'(N_DIG - 1);

    scanState_t  state, stateNxt;
    logic [1:0]  digit, digitNxt;
    logic [23:0] active, shadow;
    logic        shadowFull;
    logic        accept, promote, boundary;
    logic        tick, cntClr, cntEn;
    logic        doneDly;
    logic [7:0]  segSel;

`ifdef SEG_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
    logic [7:0] blankCnt, blankCntNxt;
`endif

    assign oFRAME_RDY = !shadowFull;
    assign accept     = iFRAME_VLD && !shadowFull;
    assign cntEn      = (state == SHOW);
    assign cntClr     = (state != SHOW);

    tick_div #(
        .DIV (TICK_DIV)
    ) uSlotDiv (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iCLR   (cntClr),
        .iEN    (cntEn),
        .oTICK  (tick)
    );

    // Next-state, digit advance, promotion and frame-boundary decode
    always_comb begin
        stateNxt = state;
        digitNxt = digit;
        promote  = 1'b0;
        boundary = 1'b0;
`ifdef SEG_BLANK_EN
        blankCntNxt = blankCnt;
`endif
        case (state)
            IDLE: begin
                if (shadowFull) begin
                    promote  = 1'b1;
                    digitNxt = '0;
                    stateNxt = SHOW;
                end
            end
            SHOW: begin
                if (tick) begin
`ifdef SEG_BLANK_EN
                    stateNxt    = BLANK;
                    blankCntNxt = '0;
`else
                    if (digit == LAST_DIG) begin
                        digitNxt = '0;
                        boundary = 1'b1;
                        promote  = shadowFull;
                    end else begin
                        digitNxt = digit + 2'd1;
                    end
`endif
                end
            end
`ifdef SEG_BLANK_EN
            BLANK: begin
                if (blankCnt == BLANK_LAST) begin
                    stateNxt = SHOW;
                    if (digit == LAST_DIG) begin
                        digitNxt = '0;
                        boundary = 1'b1;
                        promote  = shadowFull;
                    end else begin
                        digitNxt = digit + 2'd1;
                    end
                end else begin
                    blankCntNxt = blankCnt + 8'd1;
                end
            end
`endif
            default: stateNxt = IDLE;
        endcase
    end

    // Segment pattern of the current digit from the active buffer
    always_comb begin
        segSel = SEG_OFF;
        case (digit)
            2'd0:    segSel = active[7:0];
            2'd1:    segSel = active[15:8];
            2'd2:    segSel = active[23:16];
            default: segSel = SEG_OFF;
        endcase
    end

    // State, digit index and the shadow/active double buffer
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= IDLE;
            digit      <= '0;
            active     <= '0;
            shadow     <= '0;
            shadowFull <= 1'b0;
        end else begin
            state <= stateNxt;
            digit <= digitNxt;
            if (promote) begin
                active <= shadow;
            end
            // accept needs an empty shadow and promote a full one, so they never coincide
            if (accept) begin
                shadow     <= iFRAME;
                shadowFull <= 1'b1;
            end else if (promote) begin
                shadowFull <= 1'b0;
            end
        end
    end

    // Registered display outputs; the done pulse is delayed one extra cycle so it
    // lines up with the first registered digit0 cycle of the new frame
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            seg         <= SEG_OFF;
            baza        <= DIG_OFF;
            doneDly     <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            seg         <= (state == SHOW) ? segSel : SEG_OFF;
            baza        <= (state == SHOW) ? digitSel(digit) : DIG_OFF;
            doneDly     <= boundary;
            oFRAME_DONE <= doneDly;
        end
    end

`ifdef SEG_BLANK_EN
    // Blank-interval counter
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            blankCnt <= '0;
        end else begin
            blankCnt <= blankCntNxt;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4, BLANK_CYC=2.
// Expectations follow the SEG_BLANK_EN macro when it is defined.
module tb_seg_scan_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned BC = 2;
`ifdef SEG_BLANK_EN
    localparam int SLOT = TD + BC;
`else
    localparam int SLOT = TD;
`endif
    localparam int NF  = 3 * SLOT;
    localparam int OFF = NF / 2;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [23:0] iFRAME;
    logic        iFRAME_VLD;
    logic        oFRAME_RDY;
    logic [7:0]  seg;
    logic [2:0]  baza;
    logic        oFRAME_DONE;

    int checks = 0;
    int errors = 0;
    int holdK  = 0;

    seg_scan_ctrl #(
        .TICK_DIV  (TD),
        .BLANK_CYC (BC)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iFRAME      (iFRAME),
        .iFRAME_VLD  (iFRAME_VLD),
        .oFRAME_RDY  (oFRAME_RDY),
        .seg         (seg),
        .baza        (baza),
        .oFRAME_DONE (oFRAME_DONE)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkOut(input string tag, input logic [7:0] segE, input logic [2:0] bazaE,
                          input logic rdyE, input logic doneE);
        chk({tag, ".seg"},  32'(seg),         32'(segE));
        chk({tag, ".baza"}, 32'(baza),        32'(bazaE));
        chk({tag, ".rdy"},  32'(oFRAME_RDY),  32'(rdyE));
        chk({tag, ".done"}, 32'(oFRAME_DONE), 32'(doneE));
    endtask

    function automatic logic [23:0] dat(input int k);
        logic [7:0] b;
        b = 8'(3 * k);
        return {b + 8'd2, b + 8'd1, b};
    endfunction

    // mode 0: no stimulus; 1: offer mid-frame then junk; 2/3: VLD held with new data
    // every cycle; 4: drop VLD at frame start
    task automatic runFrame(input string tag, input logic [23:0] shown, input logic doneExp,
                            input int mode, input int len);
        int s, p;
        logic [7:0] segE;
        logic [2:0] bazaE;
        logic       rdyE;
        for (int i = 0; i < len; i++) begin
            s = i / SLOT;
            p = i % SLOT;
            if (p < TD) begin
                segE  = shown[8*s +: 8];
                bazaE = (s == 0) ? 3'b110 : (s == 1) ? 3'b101 : 3'b011;
            end else begin
                segE  = 8'h00;
                bazaE = 3'b111;
            end
            case (mode)
                1:       rdyE = (i <= OFF) || (i == NF - 1);
                2:       rdyE = (i == 0) || (i == NF - 1);
                3, 4:    rdyE = (i == NF - 1);
                default: rdyE = 1'b1;
            endcase
            chkOut($sformatf("%s[%0d]", tag, i), segE, bazaE, rdyE, doneExp && (i == 0));
            case (mode)
                1: begin
                    if (i == OFF) begin
                        iFRAME_VLD = 1'b1;
                        iFRAME     = 24'h010203;
                    end else if (i > OFF && i < NF - 2) begin
                        iFRAME = 24'hEEEEEE;
                    end else if (i == NF - 2) begin
                        iFRAME_VLD = 1'b0;
                    end
                end
                2, 3: begin
                    iFRAME_VLD = 1'b1;
                    iFRAME     = dat(holdK);
                    holdK++;
                end
                4: if (i == 0) iFRAME_VLD = 1'b0;
                default: ;
            endcase
            step();
        end
    endtask

    initial begin
        iRST_N     = 1'b0;
        iFRAME     = 24'h0;
        iFRAME_VLD = 1'b0;
        step();
        step();
        chkOut("reset", 8'h00, 3'b111, 1'b1, 1'b0);

        iRST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chkOut($sformatf("idle[%0d]", i), 8'h00, 3'b111, 1'b1, 1'b0);
        end

        // accept -> promote -> display
        iFRAME     = 24'hC5393F;
        iFRAME_VLD = 1'b1;
        step();
        chkOut("accept", 8'h00, 3'b111, 1'b0, 1'b0);
        iFRAME_VLD = 1'b0;
        iFRAME     = 24'h0;
        step();
        chkOut("promote", 8'h00, 3'b111, 1'b1, 1'b0);
        step();

        runFrame("frameA", 24'hC5393F, 1'b0, 0, NF);
        runFrame("frameB", 24'hC5393F, 1'b1, 1, NF);
        runFrame("frameC", 24'h010203, 1'b1, 0, NF);
        holdK = 0;
        runFrame("frameD", 24'h010203, 1'b1, 2, NF);
        runFrame("frameE", dat(0),       1'b1, 3, NF);
        runFrame("frameF", dat(NF - 1),  1'b1, 4, NF);
        runFrame("frameG", dat(2*NF - 1), 1'b1, 0, SLOT + 2);

        // one-cycle reset while digit1 is on the bus
        chkOut("preRst", dat(2*NF - 1) >> 8, 3'b101, 1'b1, 1'b0);
        iRST_N = 1'b0;
        step();
        iRST_N = 1'b1;
        chkOut("midRst", 8'h00, 3'b111, 1'b1, 1'b0);
        for (int i = 0; i < NF + 2; i++) begin
            step();
            chkOut($sformatf("postRst[%0d]", i), 8'h00, 3'b111, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
